// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the decode, ID/EX and ALU blocks.
//   - ALUOp class codes produced by the main decoder
//   - 4-bit ALU control codes consumed by the ALU
//   - R-type funct field values
//   - control-bit bundle carried through the ID/EX stage
package cpu_pkg;

  // ALUOp classes from the main decoder
  localparam logic [2:0] ALUOP_ADD   = 3'd0;  // lw/sw/addi
  localparam logic [2:0] ALUOP_SUB   = 3'd1;  // beq/bne
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;  // decode by funct
  localparam logic [2:0] ALUOP_AND   = 3'd3;  // andi
  localparam logic [2:0] ALUOP_OR    = 3'd4;  // ori
  localparam logic [2:0] ALUOP_SLT   = 3'd5;  // slti
  localparam logic [2:0] ALUOP_PASS  = 3'd6;  // bgez
  localparam logic [2:0] ALUOP_NONE  = 3'd7;

  // ALU control codes
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_MUL  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_PASS = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd12;
  localparam logic [3:0] ALU_NOP  = 4'd15;  // ALU drives 0

  // R-type funct values
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  // Control bits that must be cleared for a bubble
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } idex_ctrl_t;

endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: combinational ALUOp/funct -> 4-bit ALU control decoder.
// Ports:
//   alu_op_i   [2:0] ALUOp class from the main decoder
//   funct_i    [5:0] instruction funct field (used only for R-type)
//   alu_ctrl_o [3:0] ALU control code
module alu_ctrl
  import cpu_pkg::*;
(
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o
);

  // Class decode; unknown classes and funct values map to the NOP code
  always_comb begin
    alu_ctrl_o = ALU_NOP;
    case (alu_op_i)
      ALUOP_ADD:   alu_ctrl_o = ALU_ADD;
      ALUOP_SUB:   alu_ctrl_o = ALU_SUB;
      ALUOP_AND:   alu_ctrl_o = ALU_AND;
      ALUOP_OR:    alu_ctrl_o = ALU_OR;
      ALUOP_SLT:   alu_ctrl_o = ALU_SLT;
      ALUOP_PASS:  alu_ctrl_o = ALU_PASS;
      ALUOP_NONE:  alu_ctrl_o = ALU_NOP;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD:  alu_ctrl_o = ALU_ADD;
          FUNCT_SUB:  alu_ctrl_o = ALU_SUB;
          FUNCT_AND:  alu_ctrl_o = ALU_AND;
          FUNCT_OR:   alu_ctrl_o = ALU_OR;
          FUNCT_NOR:  alu_ctrl_o = ALU_NOR;
          FUNCT_SLT:  alu_ctrl_o = ALU_SLT;
          FUNCT_MULT: alu_ctrl_o = ALU_MUL;
          default:    alu_ctrl_o = ALU_NOP;
        endcase
      end
      default:     alu_ctrl_o = ALU_NOP;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
// Registers decoded operands, destination, ALU control code and control
// bits; applies EX/MEM and MEM/WB forwarding on the registered rs/rt.
// Ports:
//   clk_i, rst_i (async, active-high), stall_i (hold), flush_i (bubble)
//   valid_i, rs/rt/imm data, rs/rt/rd addresses, alu_op_i, funct_i,
//   alu_src_i, reg_dst_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i
//   exmem_* / memwb_* : producer write-enable, destination and result
//   valid_o, src1_o, src2_o, alu_ctrl_o, store_data_o, write_reg_o,
//   reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic [2:0]    alu_op_i,
  input  logic [5:0]    funct_i,
  input  logic          alu_src_i,
  input  logic          reg_dst_i,
  input  logic          reg_write_i,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic          mem_to_reg_i,
  input  logic          exmem_reg_write_i,
  input  logic [AW-1:0] exmem_rd_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic          memwb_reg_write_i,
  input  logic [AW-1:0] memwb_rd_i,
  input  logic [DW-1:0] memwb_result_i,
  output logic          valid_o,
  output logic [DW-1:0] src1_o,
  output logic [DW-1:0] src2_o,
  output logic [3:0]    alu_ctrl_o,
  output logic [DW-1:0] store_data_o,
  output logic [AW-1:0] write_reg_o,
  output logic          reg_write_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          mem_to_reg_o
);

  // Stage registers
  idex_ctrl_t    ctrl_q,     ctrl_d;
  logic [DW-1:0] rs_data_q,  rs_data_d;
  logic [DW-1:0] rt_data_q,  rt_data_d;
  logic [DW-1:0] imm_q,      imm_d;
  logic [AW-1:0] rs_addr_q,  rs_addr_d;
  logic [AW-1:0] rt_addr_q,  rt_addr_d;
  logic [AW-1:0] wreg_q,     wreg_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic          alu_src_q,  alu_src_d;

  logic [3:0]    alu_ctrl_s;
  logic          load_data_s;
  logic [DW-1:0] fwd_rs_s;
  logic [DW-1:0] fwd_rt_s;

  // Priority forwarding mux: EX/MEM beats MEM/WB, r0 is never forwarded
  function automatic logic [DW-1:0] fwd_sel(
    input logic [AW-1:0] addr,
    input logic [DW-1:0] reg_val,
    input logic          ex_we,
    input logic [AW-1:0] ex_rd,
    input logic [DW-1:0] ex_res,
    input logic          wb_we,
    input logic [AW-1:0] wb_rd,
    input logic [DW-1:0] wb_res
  );
    logic [DW-1:0] r;
    if (ex_we && (ex_rd != {AW{1'b0}}) && (ex_rd == addr)) begin
      r = ex_res;
    end else if (wb_we && (wb_rd != {AW{1'b0}}) && (wb_rd == addr)) begin
      r = wb_res;
    end else begin
      r = reg_val;
    end
    return r;
  endfunction

  alu_ctrl u_alu_ctrl (
    .alu_op_i   (alu_op_i),
    .funct_i    (funct_i),
    .alu_ctrl_o (alu_ctrl_s)
  );

  // Data registers load on flush as well as on a normal capture
  assign load_data_s = flush_i | ~stall_i;

  // Next-state: data path follows load_data_s, control obeys flush > stall > capture
  always_comb begin
    if (load_data_s) begin
      rs_data_d  = rs_data_i;
      rt_data_d  = rt_data_i;
      imm_d      = imm_i;
      rs_addr_d  = rs_addr_i;
      rt_addr_d  = rt_addr_i;
      wreg_d     = reg_dst_i ? rd_addr_i : rt_addr_i;
      alu_ctrl_d = alu_ctrl_s;
      alu_src_d  = alu_src_i;
    end else begin
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      rs_addr_d  = rs_addr_q;
      rt_addr_d  = rt_addr_q;
      wreg_d     = wreg_q;
      alu_ctrl_d = alu_ctrl_q;
      alu_src_d  = alu_src_q;
    end

    if (flush_i) begin
      ctrl_d = '0;
    end else if (stall_i) begin
      ctrl_d = ctrl_q;
    end else begin
      // Control bits are gated by valid so a non-instruction is a bubble
      ctrl_d.valid      = valid_i;
      ctrl_d.reg_write  = reg_write_i  & valid_i;
      ctrl_d.mem_read   = mem_read_i   & valid_i;
      ctrl_d.mem_write  = mem_write_i  & valid_i;
      ctrl_d.mem_to_reg = mem_to_reg_i & valid_i;
    end
  end

  // Stage register update with asynchronous clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      rs_data_q  <= {DW{1'b0}};
      rt_data_q  <= {DW{1'b0}};
      imm_q      <= {DW{1'b0}};
      rs_addr_q  <= {AW{1'b0}};
      rt_addr_q  <= {AW{1'b0}};
      wreg_q     <= {AW{1'b0}};
      alu_ctrl_q <= 4'd0;
      alu_src_q  <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      wreg_q     <= wreg_d;
      alu_ctrl_q <= alu_ctrl_d;
      alu_src_q  <= alu_src_d;
    end
  end

  // Forwarding is live every cycle so a stalled instruction sees new results
  assign fwd_rs_s = fwd_sel(rs_addr_q, rs_data_q,
                            exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                            memwb_reg_write_i, memwb_rd_i, memwb_result_i);
  assign fwd_rt_s = fwd_sel(rt_addr_q, rt_data_q,
                            exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                            memwb_reg_write_i, memwb_rd_i, memwb_result_i);

  assign src1_o       = fwd_rs_s;
  assign store_data_o = fwd_rt_s;
  assign src2_o       = alu_src_q ? imm_q : fwd_rt_s;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign write_reg_o  = wreg_q;
  assign valid_o      = ctrl_q.valid;
  assign reg_write_o  = ctrl_q.reg_write;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;

endmodule
